// File: rtl/ex_result_forward_pipe.sv
// ============================================================================
// Module      : ex_result_forward_pipe
// Description : EX/MEM and MEM/WB pipeline registers downstream of the ALU.
//               Drives the register-file writeback port, forwards in-flight
//               results back to the EX operands and flags load-use hazards.
//
// Parameters  : XLEN - datapath width
//               RAW  - register address width
//
// Ports       : clk, rst            clock, asynchronous active-high reset
//               ex_valid/ex_wen/ex_is_load/ex_rd/ex_alu_res
//                                   instruction currently leaving EX
//               ex_rs1/ex_rs2       EX source registers
//               rf_rs1/rf_rs2       register-file values for those sources
//               mem_rdata           data-memory read data for the MEM entry
//               stall               hold both stages (wins over flush)
//               flush               turn the EX instruction into a bubble
//               opnd_a/opnd_b       forwarded EX operands (combinational)
//               load_use            EX reads the rd of a load sitting in MEM
//               mem_alu_res         EX/MEM ALU result (data-memory address)
//               wb_valid/wb_wen/wb_rd/wb_data
//                                   MEM/WB writeback port
//
// Options     : FWD_STATS_EN - adds stat_fwd_cnt / stat_lu_cnt counters
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_result_forward_pipe #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_wen,
    input  logic            ex_is_load,
    input  logic [RAW-1:0]  ex_rd,
    input  logic [XLEN-1:0] ex_alu_res,
    input  logic [RAW-1:0]  ex_rs1,
    input  logic [RAW-1:0]  ex_rs2,
    input  logic [XLEN-1:0] rf_rs1,
    input  logic [XLEN-1:0] rf_rs2,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            stall,
    input  logic            flush,
    output logic [XLEN-1:0] opnd_a,
    output logic [XLEN-1:0] opnd_b,
    output logic            load_use,
    output logic [XLEN-1:0] mem_alu_res,
    output logic            wb_valid,
    output logic            wb_wen,
    output logic [RAW-1:0]  wb_rd,
    output logic [XLEN-1:0] wb_data
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]     stat_fwd_cnt,
    output logic [31:0]     stat_lu_cnt
`endif
);

    localparam logic [RAW-1:0] c_X0 = '0;

    // ------------------------------------------------------------------
    // EX/MEM stage (M)
    // ------------------------------------------------------------------
    logic            r_m_valid;
    logic            r_m_wen;
    logic            r_m_is_load;
    logic [RAW-1:0]  r_m_rd;
    logic [XLEN-1:0] r_m_alu_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m_valid   <= 1'b0;
            r_m_wen     <= 1'b0;
            r_m_is_load <= 1'b0;
            r_m_rd      <= '0;
            r_m_alu_res <= '0;
        end else if (!stall) begin
            // A flushed instruction still moves its fields along, but as a
            // bubble that can neither write back nor be forwarded.
            r_m_valid   <= ex_valid & ~flush;
            r_m_wen     <= ex_wen & ~flush;
            r_m_is_load <= ex_is_load;
            r_m_rd      <= ex_rd;
            r_m_alu_res <= ex_alu_res;
        end
    end

    // ------------------------------------------------------------------
    // MEM/WB stage (W)
    // ------------------------------------------------------------------
    logic            r_w_valid;
    logic            r_w_wen;
    logic [RAW-1:0]  r_w_rd;
    logic [XLEN-1:0] r_w_data;
    logic [XLEN-1:0] w_m_result;

    // Loads take their result from memory in the MEM cycle.
    assign w_m_result = r_m_is_load ? mem_rdata : r_m_alu_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w_valid <= 1'b0;
            r_w_wen   <= 1'b0;
            r_w_rd    <= '0;
            r_w_data  <= '0;
        end else if (!stall) begin
            r_w_valid <= r_m_valid;
            r_w_wen   <= r_m_wen;
            r_w_rd    <= r_m_rd;
            r_w_data  <= w_m_result;
        end
    end

    assign mem_alu_res = r_m_alu_res;
    assign wb_valid    = r_w_valid;
    assign wb_wen      = r_w_wen;
    assign wb_rd       = r_w_rd;
    assign wb_data     = r_w_data;

    // ------------------------------------------------------------------
    // Operand forwarding: index 0 is operand A, index 1 is operand B.
    // ------------------------------------------------------------------
    logic [RAW-1:0]  w_rs   [2];
    logic [XLEN-1:0] w_rf   [2];
    logic [XLEN-1:0] w_opnd [2];
    logic [1:0]      w_m_rd_match;
`ifdef FWD_STATS_EN
    logic [1:0]      w_fwd_taken;
`endif

    assign w_rs[0] = ex_rs1;
    assign w_rs[1] = ex_rs2;
    assign w_rf[0] = rf_rs1;
    assign w_rf[1] = rf_rs2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            logic w_nz;
            logic w_hit_m;
            logic w_hit_w;

            // x0 is hardwired; a pending write to it must never be seen.
            assign w_nz    = (w_rs[gi] != c_X0);
            // A load in M has no data yet, so it is skipped here and the
            // W entry (if any) becomes the source instead.
            assign w_hit_m = w_nz & r_m_valid & r_m_wen & ~r_m_is_load
                           & (r_m_rd == w_rs[gi]);
            assign w_hit_w = w_nz & r_w_valid & r_w_wen
                           & (r_w_rd == w_rs[gi]);

            assign w_opnd[gi] = w_hit_m ? r_m_alu_res :
                                w_hit_w ? r_w_data    : w_rf[gi];

            assign w_m_rd_match[gi] = (r_m_rd == w_rs[gi]);
`ifdef FWD_STATS_EN
            assign w_fwd_taken[gi] = w_hit_m | w_hit_w;
`endif
        end
    endgenerate

    assign opnd_a = w_opnd[0];
    assign opnd_b = w_opnd[1];

    // Independent of stall: the hazard unit must see it even while the
    // front end is already held.
    assign load_use = r_m_valid & r_m_wen & r_m_is_load
                    & (r_m_rd != c_X0) & (|w_m_rd_match);

`ifdef FWD_STATS_EN
    // ------------------------------------------------------------------
    // Event counters; both wrap naturally at 2^32.
    // ------------------------------------------------------------------
    logic [31:0] r_fwd_cnt;
    logic [31:0] r_lu_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fwd_cnt <= '0;
            r_lu_cnt  <= '0;
        end else begin
            if (!stall && ex_valid && (|w_fwd_taken)) begin
                r_fwd_cnt <= r_fwd_cnt + 32'd1;
            end
            if (load_use) begin
                r_lu_cnt <= r_lu_cnt + 32'd1;
            end
        end
    end

    assign stat_fwd_cnt = r_fwd_cnt;
    assign stat_lu_cnt  = r_lu_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_result_forward_pipe.sv
// ============================================================================
// Module      : tb_ex_result_forward_pipe
// Description : Randomized scoreboard bench for ex_result_forward_pipe. The
//               reference keeps the in-flight instructions as a youngest-
//               first list and answers operand/hazard queries by searching
//               it; writebacks are queued at issue and matched on retire.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_result_forward_pipe;

    localparam int NCYC   = 2000;
    localparam int RST_AT = 900;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_wen, ex_is_load;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic [31:0] ex_alu_res, rf_rs1, rf_rs2, mem_rdata;
    logic        stall, flush;
    logic [31:0] opnd_a, opnd_b, mem_alu_res, wb_data;
    logic        load_use, wb_valid, wb_wen;
    logic [4:0]  wb_rd;
`ifdef FWD_STATS_EN
    logic [31:0] stat_fwd_cnt, stat_lu_cnt;
`endif

    always #5 clk = ~clk;

    ex_result_forward_pipe #(.XLEN(32), .RAW(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_wen      (ex_wen),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .ex_alu_res  (ex_alu_res),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .rf_rs1      (rf_rs1),
        .rf_rs2      (rf_rs2),
        .mem_rdata   (mem_rdata),
        .stall       (stall),
        .flush       (flush),
        .opnd_a      (opnd_a),
        .opnd_b      (opnd_b),
        .load_use    (load_use),
        .mem_alu_res (mem_alu_res),
        .wb_valid    (wb_valid),
        .wb_wen      (wb_wen),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data)
`ifdef FWD_STATS_EN
        ,
        .stat_fwd_cnt(stat_fwd_cnt),
        .stat_lu_cnt (stat_lu_cnt)
`endif
    );

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    typedef struct {
        bit          valid;
        bit          wen;
        bit          is_load;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] memval;   // data memory returns this while it is in MEM
    } ent_t;

    typedef struct {
        bit          wen;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    typedef struct {
        logic [31:0] opa;
        logic [31:0] opb;
        bit          lu;
        logic [31:0] mar;
        bit          wbv;
        logic [31:0] fwd_cnt;
        logic [31:0] lu_cnt;
    } comb_t;

    ent_t  pipe[$];      // [0] = youngest in flight (MEM), [1] = oldest (WB)
    wb_t   wb_q[$];
    comb_t comb_q[$];

    logic [31:0] cur_memval;
    logic [31:0] exp_fwd_cnt, exp_lu_cnt;
    bit          pend_fwd, pend_lu;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Value EX should see for register rs: youngest in-flight writer that
    // already has its result; a load still in MEM has none yet.
    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rf,
                                        output bit taken);
        taken = 1'b0;
        if (rs == 5'd0) return rf;
        for (int i = 0; i < pipe.size(); i++) begin
            if (pipe[i].valid && pipe[i].wen && pipe[i].rd == rs) begin
                if (i == 0 && pipe[i].is_load) continue;
                taken = 1'b1;
                return pipe[i].is_load ? pipe[i].memval : pipe[i].alu;
            end
        end
        return rf;
    endfunction

    function automatic ent_t bubble();
        ent_t e;
        e.valid = 0; e.wen = 0; e.is_load = 0; e.rd = '0; e.alu = '0; e.memval = '0;
        return e;
    endfunction

    task automatic model_reset();
        pipe.delete();
        pipe.push_back(bubble());
        pipe.push_back(bubble());
        wb_q.delete();
        exp_fwd_cnt = '0;
        exp_lu_cnt  = '0;
    endtask

    // ------------------------------------------------------------------
    // Driver: advances the model across each edge, then issues new stimulus
    // and pushes the expected combinational response.
    // ------------------------------------------------------------------
    initial begin
        ent_t  n;
        comb_t e;
        bit    ta, tb, drain;

        rst = 1'b1;
        ex_valid = 0; ex_wen = 0; ex_is_load = 0; ex_rd = '0; ex_alu_res = '0;
        ex_rs1 = '0; ex_rs2 = '0; rf_rs1 = '0; rf_rs2 = '0; mem_rdata = '0;
        stall = 0; flush = 0; cur_memval = '0; pend_fwd = 0; pend_lu = 0;
        model_reset();

        #1;
        chk("reset_mem_alu_res", mem_alu_res, 32'd0);
        chk("reset_wb_valid",    {31'd0, wb_valid}, 32'd0);
        chk("reset_wb_wen",      {31'd0, wb_wen}, 32'd0);
        chk("reset_wb_rd",       {27'd0, wb_rd}, 32'd0);
        chk("reset_wb_data",     wb_data, 32'd0);

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            // Effect of the edge that just happened, using the inputs we drove.
            if (!rst) begin
                if (!stall) begin
                    n.valid   = ex_valid && !flush;
                    n.wen     = ex_wen && !flush;
                    n.is_load = ex_is_load;
                    n.rd      = ex_rd;
                    n.alu     = ex_alu_res;
                    n.memval  = cur_memval;
                    pipe.push_front(n);
                    void'(pipe.pop_back());
                    if (n.valid)
                        wb_q.push_back('{wen: n.wen, rd: n.rd,
                                         data: n.is_load ? n.memval : n.alu});
                end
                if (pend_fwd) exp_fwd_cnt = exp_fwd_cnt + 32'd1;
                if (pend_lu)  exp_lu_cnt  = exp_lu_cnt + 32'd1;
            end

            if (c == 2) rst = 1'b0;
            if (c == RST_AT) begin
                rst = 1'b1;
                model_reset();
                #1;
                chk("midrst_wb_valid",    {31'd0, wb_valid}, 32'd0);
                chk("midrst_wb_data",     wb_data, 32'd0);
                chk("midrst_mem_alu_res", mem_alu_res, 32'd0);
            end
            if (c == RST_AT + 2) rst = 1'b0;

            drain = (c >= NCYC - 6);

            // New stimulus; small register space gives frequent hazards.
            ex_valid   = drain ? 1'b0 : ($urandom_range(0, 9) < 8);
            ex_wen     = ($urandom_range(0, 9) < 8);
            ex_is_load = ($urandom_range(0, 3) == 0);
            ex_rd      = 5'($urandom_range(0, 7));
            ex_alu_res = $urandom;
            ex_rs1     = 5'($urandom_range(0, 7));
            ex_rs2     = 5'($urandom_range(0, 7));
            rf_rs1     = $urandom;
            rf_rs2     = $urandom;
            stall      = drain ? 1'b0 : ($urandom_range(0, 4) == 0);
            flush      = drain ? 1'b0 : ($urandom_range(0, 9) == 0);
            cur_memval = $urandom;
            mem_rdata  = pipe[0].is_load ? pipe[0].memval : $urandom;

            e.opa     = fwd(ex_rs1, rf_rs1, ta);
            e.opb     = fwd(ex_rs2, rf_rs2, tb);
            e.lu      = pipe[0].valid && pipe[0].wen && pipe[0].is_load && pipe[0].rd != 0
                        && (pipe[0].rd == ex_rs1 || pipe[0].rd == ex_rs2);
            e.mar     = pipe[0].alu;
            e.wbv     = pipe[1].valid;
            e.fwd_cnt = exp_fwd_cnt;
            e.lu_cnt  = exp_lu_cnt;
            comb_q.push_back(e);

            pend_fwd = !stall && ex_valid && (ta || tb);
            pend_lu  = e.lu;
        end

        @(negedge clk);
        #1;
        chk("wb_queue_drained",   wb_q.size(), 32'd0);
        chk("comb_queue_drained", comb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ------------------------------------------------------------------
    // Monitor: compares combinational outputs every cycle and pops a
    // writeback expectation whenever a new entry lands in WB.
    // ------------------------------------------------------------------
    initial begin
        bit    s_stall, s_rst;
        comb_t e;
        wb_t   w;
        forever begin
            @(posedge clk);
            s_stall = stall;
            s_rst   = rst;
            @(negedge clk);
            if (comb_q.size() > 0) begin
                e = comb_q.pop_front();
                chk("opnd_a",      opnd_a, e.opa);
                chk("opnd_b",      opnd_b, e.opb);
                chk("load_use",    {31'd0, load_use}, {31'd0, e.lu});
                chk("mem_alu_res", mem_alu_res, e.mar);
                chk("wb_valid",    {31'd0, wb_valid}, {31'd0, e.wbv});
`ifdef FWD_STATS_EN
                chk("stat_fwd_cnt", stat_fwd_cnt, e.fwd_cnt);
                chk("stat_lu_cnt",  stat_lu_cnt,  e.lu_cnt);
`endif
            end
            if (!s_rst && !s_stall && wb_valid) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", {31'd0, wb_valid}, 32'd0);
                end else begin
                    w = wb_q.pop_front();
                    chk("wb_wen",  {31'd0, wb_wen}, {31'd0, w.wen});
                    chk("wb_rd",   {27'd0, wb_rd}, {27'd0, w.rd});
                    chk("wb_data", wb_data, w.data);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #((NCYC + 100) * 10);
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
